// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/FLUSH sequencing with kill window after redirects.
// Optional misaligned-redirect trap enabled by defining PC_GEN_MISALIGN_TRAP_EN.
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned IFU_LATENCY  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_add,
    output logic        fetch_valid,
    output logic        kill,
    output logic        misalign
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [2:0] KILL_LOAD = 3'(IFU_LATENCY);

    logic [1:0]  state;
    logic [2:0]  kill_cnt;
    logic [31:0] redirect_addr;
    logic        redirect_misaligned;

`ifdef PC_GEN_MISALIGN_TRAP_EN
    always_comb begin
        redirect_misaligned = |redirect_target[1:0];
        redirect_addr       = redirect_misaligned ? TRAP_VECTOR : redirect_target;
    end
`else
    // Low target bits are dropped silently in this build.
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];

    always_comb begin
        redirect_misaligned = 1'b0;
        redirect_addr       = {redirect_target[31:2], 2'b00};
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            fetch_add   <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            kill        <= 1'b0;
            misalign    <= 1'b0;
            kill_cnt    <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN, FLUSH: begin
                    if (redirect_valid) begin
                        fetch_add <= redirect_addr;
                        state     <= FLUSH;
                        kill_cnt  <= KILL_LOAD;
                        kill      <= 1'b1;
                        misalign  <= redirect_misaligned;
                    end else begin
                        if (!stall) begin
                            fetch_add <= fetch_add + 32'd4;
                        end
                        // kill mirrors the counter's next value so it drops with the return to RUN.
                        if (state == FLUSH) begin
                            kill_cnt <= kill_cnt - 3'd1;
                            kill     <= (kill_cnt > 3'd1);
                            if (kill_cnt <= 3'd1) begin
                                state <= RUN;
                            end
                        end
                    end
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    kill        <= 1'b0;
                    kill_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then random stall/redirect traffic
// checked against a cycle-count based reference model.
module tb_pc_gen;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam int          LAT = 2;
`ifdef PC_GEN_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] fetch_add;
    logic        fetch_valid;
    logic        kill;
    logic        misalign;

    pc_gen #(
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV),
        .IFU_LATENCY (LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .fetch_add      (fetch_add),
        .fetch_valid    (fetch_valid),
        .kill           (kill),
        .misalign       (misalign)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: kill is derived from how many edges have passed since the last redirect.
    bit          m_boot;
    logic [31:0] m_addr;
    logic        m_valid;
    logic        m_kill;
    logic        m_mis;
    int          cyc = 0;
    int          last_rd = -1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".fetch_add"}, fetch_add, m_addr);
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_valid});
        check({tag, ".kill"}, {31'd0, kill}, {31'd0, m_kill});
        check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
    endtask

    task automatic model_edge(input logic st, input logic rv, input logic [31:0] tgt);
        logic [1:0] low;
        cyc++;
        m_mis = 1'b0;
        low   = tgt[1:0];
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else if (rv) begin
            if (TRAP_EN && low != 2'b00) begin
                m_addr = TV;
                m_mis  = 1'b1;
            end else begin
                m_addr = tgt - (tgt % 4);
            end
            last_rd = cyc;
        end else if (!st) begin
            m_addr = m_addr + 32'd4;
        end
        m_kill = ((cyc - last_rd) < LAT);
    endtask

    task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] tgt);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clock);
        #1;
        model_edge(st, rv, tgt);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m_boot  = 1'b1;
        m_addr  = RV;
        m_valid = 1'b0;
        m_kill  = 1'b0;
        m_mis   = 1'b0;
        last_rd = -1000;
        check_all(tag);
        @(posedge clock);
        #1;
        check_all({tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        logic        r_st, r_rv;
        logic [31:0] r_tgt;

        do_reset("reset");
        step("boot_exit", 1'b0, 1'b0, 32'h0);
        step("run_4", 1'b0, 1'b0, 32'h0);
        step("run_8", 1'b0, 1'b0, 32'h0);
        step("run_c", 1'b0, 1'b0, 32'h0);
        step("run_10", 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b1, 1'b0, 32'h0);
        step("stall_release", 1'b0, 1'b0, 32'h0);

        step("redir_200", 1'b0, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) step("redir_200_after", 1'b0, 1'b0, 32'h0);

        step("redir_300", 1'b0, 1'b1, 32'h300);
        step("redir_400_stalled", 1'b1, 1'b1, 32'h400);
        for (int i = 0; i < 3; i++) step("redir_400_hold", 1'b1, 1'b0, 32'h0);

        step("redir_202", 1'b0, 1'b1, 32'h202);
        for (int i = 0; i < 3; i++) step("redir_202_after", 1'b0, 1'b0, 32'h0);

        step("redir_fffffffc", 1'b0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) step("wrap", 1'b0, 1'b0, 32'h0);

        step("flush_then_reset", 1'b0, 1'b1, 32'h500);
        do_reset("reset_mid_flush");
        for (int i = 0; i < 5; i++) step("after_flush_reset", 1'b0, 1'b0, 32'h0);

        step("boot_ignore_setup", 1'b0, 1'b1, 32'h600);
        do_reset("reset_again");
        step("boot_ignores_redirect", 1'b1, 1'b1, 32'h700);
        step("post_boot", 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            r_st  = ($urandom_range(0, 3) == 0);
            r_rv  = ($urandom_range(0, 5) == 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) r_tgt = 32'hFFFF_FFF4;
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rand_reset");
            end
            step("random", r_st, r_rv, r_tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
